// File: rtl/updown_counter_param_if.sv
// Bus bundle for the up/down counter: control inputs and status outputs.
interface updown_counter_param_if #(
  parameter int WIDTH = 8
);
  logic             counter_en;
  logic             add_or_sub;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] limit;
  logic             sat_mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clear_flags;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_min;
  logic             wrap_pulse;
  logic             ovf_sticky;
  logic             unf_sticky;

  modport master (
    output counter_en, add_or_sub, step, limit, sat_mode, load, load_val, clear_flags,
    input  count, at_max, at_min, wrap_pulse, ovf_sticky, unf_sticky
  );

  modport slave (
    input  counter_en, add_or_sub, step, limit, sat_mode, load, load_val, clear_flags,
    output count, at_max, at_min, wrap_pulse, ovf_sticky, unf_sticky
  );
endinterface

// File: rtl/updown_counter_param.sv
// Bounded up/down counter with wrap or saturate behaviour, load, sticky
// overflow/underflow flags and a one-cycle wrap pulse.
module updown_counter_param #(
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  updown_counter_param_if.slave bus
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  typedef logic [WIDTH:0] ext_t;

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             ovf_q;
  logic             unf_q;

  ext_t cnt_x, lim_x, step_x, eff_x, ldv_x, sum_x, nxt_x;
  logic ovf_evt, unf_evt, wrap_evt;
  logic unused_msb;

  // Next count and event decode; one extra bit keeps every sum exact.
  always_comb begin
    cnt_x    = {1'b0, count_q};
    lim_x    = {1'b0, bus.limit};
    step_x   = {1'b0, bus.step};
    ldv_x    = {1'b0, bus.load_val};
    eff_x    = (step_x > lim_x) ? lim_x : step_x;
    sum_x    = cnt_x + eff_x;
    nxt_x    = cnt_x;
    ovf_evt  = 1'b0;
    unf_evt  = 1'b0;
    wrap_evt = 1'b0;
    if (bus.load) begin
      nxt_x = (ldv_x > lim_x) ? lim_x : ldv_x;
    end else if (bus.counter_en) begin
      if (cnt_x > lim_x) begin
        // limit dropped below the count: snap to it silently
        nxt_x = lim_x;
      end else if (eff_x != '0) begin
        if (bus.add_or_sub) begin
          if (sum_x <= lim_x) begin
            nxt_x = sum_x;
          end else begin
            ovf_evt  = 1'b1;
            wrap_evt = ~bus.sat_mode;
            nxt_x    = bus.sat_mode ? lim_x : sum_x - (lim_x + ext_t'(1));
          end
        end else begin
          if (cnt_x >= eff_x) begin
            nxt_x = cnt_x - eff_x;
          end else begin
            unf_evt  = 1'b1;
            wrap_evt = ~bus.sat_mode;
            nxt_x    = bus.sat_mode ? '0 : (cnt_x + lim_x + ext_t'(1)) - eff_x;
          end
        end
      end
    end
  end

  // The result always fits in WIDTH bits; the top bit is headroom only.
  assign unused_msb = nxt_x[WIDTH];

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) count_q <= RST_VAL;
    else       count_q <= nxt_x[WIDTH-1:0];
  end

  // Wrap pulse follows the edge that applied a wrap.
  always_ff @(posedge clock) begin
    if (reset) wrap_q <= 1'b0;
    else       wrap_q <= wrap_evt;
  end

  // Sticky flags: an event beats a same-cycle clear; load freezes them.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!bus.load) begin
      ovf_q <= ovf_evt | (ovf_q & ~bus.clear_flags);
      unf_q <= unf_evt | (unf_q & ~bus.clear_flags);
    end
  end

  assign bus.count      = count_q;
  assign bus.at_max     = (count_q == bus.limit);
  assign bus.at_min     = (count_q == '0);
  assign bus.wrap_pulse = wrap_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.unf_sticky = unf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed table-driven bench for updown_counter_param (WIDTH=4, RESET_VAL=0).
module tb_updown_counter_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  updown_counter_param_if #(.WIDTH(4)) bus ();

  updown_counter_param #(.WIDTH(4), .RESET_VAL(0)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       en, up, sat, ld, clr;
    logic [3:0] step, lim, lv;
    logic [3:0] e_cnt;
    logic       e_wr, e_ovf, e_unf, e_max, e_min;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic up, logic sat, logic ld, logic clr,
                              logic [3:0] step, logic [3:0] lim, logic [3:0] lv,
                              logic [3:0] e_cnt, logic e_wr, logic e_ovf,
                              logic e_unf, logic e_max, logic e_min);
    vec_t v;
    v.en = en; v.up = up; v.sat = sat; v.ld = ld; v.clr = clr;
    v.step = step; v.lim = lim; v.lv = lv;
    v.e_cnt = e_cnt; v.e_wr = e_wr; v.e_ovf = e_ovf; v.e_unf = e_unf;
    v.e_max = e_max; v.e_min = e_min;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(logic en, logic up, logic sat, logic ld, logic clr,
                       logic [3:0] step, logic [3:0] lim, logic [3:0] lv);
    bus.counter_en  = en;
    bus.add_or_sub  = up;
    bus.sat_mode    = sat;
    bus.load        = ld;
    bus.clear_flags = clr;
    bus.step        = step;
    bus.limit       = lim;
    bus.load_val    = lv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string tag, logic [3:0] c, logic wr, logic ovf,
                         logic unf, logic mx, logic mn);
    chk({tag, ".count"},      int'(bus.count),      int'(c));
    chk({tag, ".wrap_pulse"}, int'(bus.wrap_pulse), int'(wr));
    chk({tag, ".ovf_sticky"}, int'(bus.ovf_sticky), int'(ovf));
    chk({tag, ".unf_sticky"}, int'(bus.unf_sticky), int'(unf));
    chk({tag, ".at_max"},     int'(bus.at_max),     int'(mx));
    chk({tag, ".at_min"},     int'(bus.at_min),     int'(mn));
  endtask

  initial begin
    // wrap up 0..9 then 0,1,2
    for (int i = 1; i <= 12; i++) begin
      int c;
      c = i % 10;
      vecs.push_back(mk(1,1,0,0,0, 4'd1, 4'd9, 4'd0, 4'(c), c == 0, i >= 10, 0, c == 9, c == 0));
    end
    //                en up sat ld clr step lim lv   cnt wr ovf unf max min
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'd1, 4'd9, 4'd0, 4'd2, 0, 0, 0, 0, 0));   // clear alone
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'd3, 4'd15,4'd14,4'd14,0, 0, 0, 0, 0));   // load 14
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'd3, 4'd15,4'd0, 4'd15,0, 1, 0, 1, 0));   // sat up
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'd3, 4'd15,4'd0, 4'd15,0, 1, 0, 1, 0));   // sat again
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'd1, 4'd9, 4'd0, 4'd15,0, 0, 0, 0, 0));   // clear, count>limit held
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'd3, 4'd9, 4'd1, 4'd1, 0, 0, 0, 0, 0));   // load 1
    vecs.push_back(mk(1, 0, 0, 0, 0, 4'd3, 4'd9, 4'd0, 4'd8, 1, 0, 1, 0, 0));   // wrap down
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd3, 4'd9, 4'd0, 4'd8, 0, 0, 1, 0, 0));   // hold
    vecs.push_back(mk(1, 1, 0, 1, 0, 4'd1, 4'd9, 4'd12,4'd9, 0, 0, 1, 1, 0));   // load clamp beats en
    vecs.push_back(mk(1, 1, 0, 0, 1, 4'd1, 4'd9, 4'd0, 4'd0, 1, 1, 0, 0, 1));   // set over clear
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'd1, 4'd9, 4'd0, 4'd0, 0, 0, 0, 0, 1));   // clear alone
    vecs.push_back(mk(1, 1, 0, 0, 0, 4'd0, 4'd9, 4'd0, 4'd0, 0, 0, 0, 0, 1));   // step 0
    vecs.push_back(mk(1, 1, 0, 0, 0, 4'd5, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 1));   // limit 0 up
    vecs.push_back(mk(1, 0, 0, 0, 0, 4'd5, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 1));   // limit 0 down
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd9, 4'd5, 4'd5, 0, 0, 0, 0, 0));   // load 5
    vecs.push_back(mk(1, 0, 0, 0, 0, 4'd2, 4'd9, 4'd0, 4'd3, 0, 0, 0, 0, 0));   // plain down
    vecs.push_back(mk(1, 1, 0, 0, 0, 4'd12,4'd9, 4'd0, 4'd2, 1, 1, 0, 0, 0));   // step>limit, eff=9
    vecs.push_back(mk(1, 0, 1, 0, 0, 4'd4, 4'd9, 4'd0, 4'd0, 0, 1, 1, 0, 1));   // sat down
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'd7, 4'd9, 4'd3, 4'd0, 0, 1, 1, 0, 1));   // disabled hold
    vecs.push_back(mk(1, 0, 0, 0, 0, 4'd9, 4'd9, 4'd0, 4'd1, 1, 1, 1, 0, 0));   // wrap down 0->1
    vecs.push_back(mk(1, 0, 0, 0, 0, 4'd1, 4'd9, 4'd0, 4'd0, 0, 1, 1, 0, 1));   // down to exactly 0
    vecs.push_back(mk(1, 1, 0, 0, 0, 4'd9, 4'd9, 4'd0, 4'd9, 0, 1, 1, 1, 0));   // up to exactly limit

    // reset state
    drive(1, 1, 0, 0, 0, 4'd1, 4'd9, 4'd0);
    rst = 1'b1;
    tick();
    tick();
    chk_all("reset", 4'd0, 0, 0, 0, 0, 1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].up, vecs[i].sat, vecs[i].ld, vecs[i].clr,
            vecs[i].step, vecs[i].lim, vecs[i].lv);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_wr, vecs[i].e_ovf,
              vecs[i].e_unf, vecs[i].e_max, vecs[i].e_min);
    end

    // mid-run reset: count 7 with both flags set, reset beats load/en
    drive(0, 1, 0, 1, 0, 4'd1, 4'd9, 4'd7);
    tick();
    chk_all("pre_rst", 4'd7, 0, 1, 1, 0, 0);
    drive(1, 1, 0, 1, 1, 4'd1, 4'd9, 4'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("mid_rst", 4'd0, 0, 0, 0, 0, 1);

    // limit lowered under the count, then clamp on enable
    drive(0, 1, 0, 1, 0, 4'd1, 4'd9, 4'd7);
    tick();
    chk("reload.count", int'(bus.count), 7);
    drive(0, 1, 0, 0, 0, 4'd1, 4'd3, 4'd0);
    tick();
    chk_all("low_lim_hold", 4'd7, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 4'd1, 4'd3, 4'd0);
    tick();
    chk_all("clamp", 4'd3, 0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0, 4'd1, 4'd3, 4'd0);
    tick();
    chk("clamp_after.wrap", int'(bus.wrap_pulse), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

Interface
REQ-001 Parameter WIDTH, default 8: counter and data-path width in bits; legal range 2..32.
REQ-002 Parameter RESET_VAL, default 0: count value loaded on reset.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 counter_en  input  1  count enable; 0 holds count.
REQ-006 add_or_sub  input  1  direction: 1 counts up, 0 counts down.
REQ-007 step  input  WIDTH  increment/decrement amount per enabled cycle.
REQ-008 limit  input  WIDTH  upper bound; legal count range is 0..limit.
REQ-009 sat_mode  input  1  1 saturates at bounds, 0 wraps modulo (limit+1).
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_val  input  WIDTH  value for load.
REQ-012 clear_flags  input  1  clears sticky flags.
REQ-013 count  output  WIDTH  registered counter value.
REQ-014 at_max  output  1  high while count == limit.
REQ-015 at_min  output  1  high while count == 0.
REQ-016 wrap_pulse  output  1  registered, one-cycle pulse on a wrap.
REQ-017 ovf_sticky  output  1  latched overflow indicator.
REQ-018 unf_sticky  output  1  latched underflow indicator.

Function
REQ-019 Update priority per rising edge SHALL be: reset > load > counter_en > hold.
REQ-020 count SHALL change only on a rising edge, one cycle after the qualifying inputs are sampled.
REQ-021 Effective step SHALL be eff = min(step, limit); all arithmetic SHALL use WIDTH+1 bits, so no intermediate truncation occurs.
REQ-022 Load SHALL set count = min(load_val, limit), SHALL leave sticky flags unchanged, and SHALL hold wrap_pulse low.
REQ-023 Enabled up count with count+eff <= limit SHALL set count = count+eff.
REQ-024 Enabled up count with count+eff > limit (overflow event): wrap mode sets count = count+eff-(limit+1); saturate mode sets count = limit.
REQ-025 Enabled down count with count >= eff SHALL set count = count-eff.
REQ-026 Enabled down count with count < eff (underflow event): wrap mode sets count = count+(limit+1)-eff; saturate mode sets count = 0.
REQ-027 If count > limit (limit lowered at runtime) on an enabled cycle without load, count SHALL become limit, with no event, no flag and no pulse.
REQ-028 eff == 0 (including limit == 0) SHALL hold count and SHALL raise no event.
REQ-029 wrap_pulse SHALL be 1 for exactly the cycle following an edge that applied a wrap (REQ-024/026, wrap mode only); it SHALL be 0 otherwise.
REQ-030 ovf_sticky/unf_sticky SHALL set on an overflow/underflow event in either mode, and SHALL clear on clear_flags.
REQ-031 If an event and clear_flags occur in the same cycle, set SHALL win.
REQ-032 at_max and at_min SHALL be combinational decodes of registered count and the current limit; both SHALL be high when limit == 0 and count == 0.
REQ-033 counter_en == 0 with load == 0 SHALL hold count and flags; wrap_pulse SHALL be 0.

Reset
REQ-034 On reset, these SHALL be the results at the next rising edge: count = RESET_VAL, wrap_pulse = 0, ovf_sticky = 0, unf_sticky = 0.
REQ-035 Reset SHALL override load, counter_en and clear_flags in the same cycle, and SHALL abort any in-progress count with no residual state.
REQ-036 If RESET_VAL > limit, the clamp of REQ-027 SHALL apply on the first enabled cycle.

Verification (WIDTH=4, RESET_VAL=0)
REQ-037 Wrap up: limit=9, step=1, up, sat_mode=0, en held 12 cycles -> count 1..9,0,1,2; wrap_pulse high only in the cycle count=0; ovf_sticky=1; at_max high at count=9.
REQ-038 Saturate up: limit=15, load 14, step=3, sat_mode=1, en 2 cycles -> count 15,15; ovf_sticky=1; wrap_pulse never high.
REQ-039 Wrap down: limit=9, load 1, step=3, down, en 1 cycle -> count=8; unf_sticky=1; wrap_pulse=1 for one cycle.
REQ-040 Load clamp/priority: limit=9, load=1, load_val=12, counter_en=1 same cycle -> count=9; flags unchanged; wrap_pulse=0.
REQ-041 Set-over-clear: ovf_sticky=0, overflow event with clear_flags=1 same cycle -> ovf_sticky=1; clear_flags alone next cycle -> 0.
REQ-042 Mid-run reset: count=7, flags set, reset=1 with load=1, load_val=5 -> count=0; all flags 0; limit lowered to 3 with count=7, then en -> count=3 with no flag.
